// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches code words ahead of decode and
// buffers {ir, pc} pairs in a small FIFO with a valid/ready head.
//
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr/imem_data : code memory, data 1 cycle after req
//   ir_out/pc_out/ir_valid/ir_ready : head entry handshake
//   redirect/redirect_pc : flush and restart fetch at a jump target
//   halt : stop issuing new fetches
//   count : occupied entries
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 16,
  parameter int IW = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic [IW-1:0]            imem_data,
  output logic [IW-1:0]            ir_out,
  output logic [AW-1:0]            pc_out,
  output logic                     ir_valid,
  input  logic                     ir_ready,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  input  logic                     halt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  logic [IW-1:0] ir_mem [DEPTH];
  logic [AW-1:0] pc_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] inflight_pc;
  logic          inflight;
  logic          squash;
  logic [IW-1:0] hold_ir;
  logic [AW-1:0] hold_pc;

  logic [OW-1:0] occ;
  logic          space;
  logic          push;
  logic          pop;

  // In-flight word reserves its slot, so a same-cycle pop never
  // makes room for a new request.
  assign occ = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign space = occ < OW'(DEPTH);

  assign imem_req = reset & ~halt & ~redirect & space;
  assign imem_addr = fetch_pc;

  assign ir_valid = (count != '0);
  assign push = inflight & ~squash;
  assign pop = ir_valid & ir_ready;

  // Head outputs fall back to the last presented entry once empty.
  assign ir_out = ir_valid ? ir_mem[rd_ptr] : hold_ir;
  assign pc_out = ir_valid ? pc_mem[rd_ptr] : hold_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= '0;
      inflight_pc <= '0;
      inflight <= 1'b0;
      squash <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req)
        inflight_pc <= fetch_pc;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        squash <= inflight;
      end else begin
        squash <= 1'b0;
        if (imem_req)
          fetch_pc <= fetch_pc + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      hold_ir <= '0;
      hold_pc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem[i] <= '0;
        pc_mem[i] <= '0;
      end
    end else begin
      if (ir_valid) begin
        hold_ir <= ir_mem[rd_ptr];
        hold_pc <= pc_mem[rd_ptr];
      end
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (push) begin
          ir_mem[wr_ptr] <= imem_data;
          pc_mem[wr_ptr] <= inflight_pc;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset)
    !(push && !redirect && count == CW'(DEPTH))
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: per-cycle vector table for fill/drain plus
// directed redirect, wrap, halt and async-reset sequences.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = 16'h0;
  logic [15:0] ir_out;
  logic [15:0] pc_out;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        halt = 1'b0;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(4), .AW(16), .IW(16)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .ir_out(ir_out),
    .pc_out(pc_out),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] code(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  // Code memory: registered read, garbage when not requested.
  always @(posedge clk)
    imem_data <= imem_req ? code(imem_addr) : 16'hDEAD;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pc pushed when a request issues, popped on accept.
  logic [15:0] exp_q[$];
  logic [15:0] mfpc = 16'h0;
  logic [15:0] sb_e;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      mfpc = 16'h0;
    end else begin
      if (ir_valid && ir_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_pop got pc %h want none", pc_out);
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_pc", {16'h0, pc_out}, {16'h0, sb_e});
          chk("sb_ir", {16'h0, ir_out}, {16'h0, code(sb_e)});
        end
      end
      if (imem_req) begin
        chk("sb_addr", {16'h0, imem_addr}, {16'h0, mfpc});
        exp_q.push_back(mfpc);
        mfpc = mfpc + 16'h1;
      end
      if (redirect) begin
        exp_q.delete();
        mfpc = redirect_pc;
      end
    end
  end

  typedef struct {
    logic        ready;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [2:0]  cnt;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] seen[4];
    logic [15:0] wrap_exp[4];
    int got;
    int pops;

    tbl[0]  = '{1'b0, 1'b1, 16'h0, 1'b0, 3'd0, 16'h0};
    tbl[1]  = '{1'b0, 1'b1, 16'h1, 1'b0, 3'd0, 16'h0};
    tbl[2]  = '{1'b0, 1'b1, 16'h2, 1'b1, 3'd1, 16'h0};
    tbl[3]  = '{1'b0, 1'b1, 16'h3, 1'b1, 3'd2, 16'h0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0, 1'b1, 3'd3, 16'h0};
    tbl[5]  = '{1'b0, 1'b0, 16'h0, 1'b1, 3'd4, 16'h0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0, 1'b1, 3'd4, 16'h0};
    tbl[7]  = '{1'b1, 1'b1, 16'h4, 1'b1, 3'd3, 16'h1};
    tbl[8]  = '{1'b1, 1'b1, 16'h5, 1'b1, 3'd2, 16'h2};
    tbl[9]  = '{1'b1, 1'b1, 16'h6, 1'b1, 3'd2, 16'h3};
    tbl[10] = '{1'b1, 1'b1, 16'h7, 1'b1, 3'd2, 16'h4};

    wrap_exp[0] = 16'hFFFE;
    wrap_exp[1] = 16'hFFFF;
    wrap_exp[2] = 16'h0000;
    wrap_exp[3] = 16'h0001;

    // Reset state
    repeat (2) tick();
    #2;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ir", ir_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_addr", imem_addr, 0);

    // Fill then steady drain
    tick();
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      ir_ready = tbl[i].ready;
      #2;
      chk($sformatf("v%0d_req", i), imem_req, tbl[i].req);
      if (tbl[i].req)
        chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_valid", i), ir_valid, tbl[i].valid);
      chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
      if (tbl[i].valid) begin
        chk($sformatf("v%0d_pc", i), pc_out, tbl[i].pc);
        chk($sformatf("v%0d_ir", i), ir_out, code(tbl[i].pc));
      end
    end

    // Redirect while a word is in flight
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    #2;
    chk("redir_noreq", imem_req, 0);
    tick();
    redirect = 1'b0;
    #2;
    chk("redir_req", imem_req, 1);
    chk("redir_addr", imem_addr, 16'h0040);
    chk("redir_empty", ir_valid, 0);
    chk("redir_count", count, 0);
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      tick();
      #2;
      if (ir_valid) got = 1;
    end
    chk("redir_seen", got, 1);
    chk("redir_pc", pc_out, 16'h0040);
    chk("redir_ir", ir_out, code(16'h0040));

    // pc wrap across 16'hFFFF
    tick();
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    ir_ready = 1'b1;
    tick();
    redirect = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got < 4; k++) begin
      #2;
      if (ir_valid && ir_ready) begin
        seen[got] = pc_out;
        got++;
      end
      tick();
    end
    chk("wrap_pops", got, 4);
    for (int k = 0; k < 4; k++)
      if (k < got)
        chk($sformatf("wrap_pc%0d", k), seen[k], wrap_exp[k]);

    // Halt with 2 queued and 1 in flight
    ir_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    tick();
    halt = 1'b1;
    ir_ready = 1'b1;
    #2;
    chk("halt_count", count, 2);
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        tick();
        #2;
      end
      chk($sformatf("halt_noreq%0d", k), imem_req, 0);
      if (ir_valid && ir_ready) pops++;
    end
    chk("halt_pops", pops, 3);
    chk("halt_valid", ir_valid, 0);
    chk("halt_empty", count, 0);
    tick();
    halt = 1'b0;
    #2;
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, 16'h0103);

    // Async reset mid-fill
    ir_ready = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", ir_valid, 0);
    chk("arst_req", imem_req, 0);
    tick();
    tick();
    reset = 1'b1;
    #2;
    chk("arst_req1", imem_req, 1);
    chk("arst_addr0", imem_addr, 16'h0);
    tick();
    #2;
    chk("arst_addr1", imem_addr, 16'h1);
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      tick();
      #2;
      if (ir_valid) got = 1;
    end
    chk("arst_seen", got, 1);
    chk("arst_pc", pc_out, 16'h0);
    chk("arst_ir", ir_out, 16'h1000);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
